// File: rtl/vec_dot_accum.sv
// vec_dot_accum: multi-lane dot-product / sum-of-squares engine.
// Multiplies LANES elements per cycle in a registered product stage, then
// feeds a saturating accumulator. Results use signed Q-format fixed point.
// Optional build macro VEC_DOT_ROUND_EN: round products to nearest before
// saturation. When the macro is undefined, products are truncated (floor).
module vec_dot_accum #(
  parameter int unsigned I     = 20,
  parameter int unsigned Q     = 15,
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] in_a [I],
  input  logic [N-1:0] in_b [I],
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         ovfl
);

  localparam int unsigned G  = (I + LANES - 1) / LANES;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned PW = 2 * N;
  // One bit beyond the lane-sum width so that adding acc can never wrap
  localparam int unsigned SW = N + $clog2(LANES) + 1;

`ifdef VEC_DOT_ROUND_EN
  localparam logic signed [PW-1:0] RND = (Q > 0) ? (PW'(1) << (Q - 1)) : '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  idx_q, idx_d;
  logic           mode_q, mode_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   prod_q [LANES];
  logic [N-1:0]   prod_d [LANES];
  logic           prod_vld_q, prod_vld_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovfl_q, ovfl_d;

  logic [N-1:0]   grp_prod [LANES];
  logic           grp_ovf;
  logic [N-1:0]   acc_sat;
  logic           acc_ovf;

  // Signed product, Q-shift (optionally rounded) and saturate; MSB flags saturation
  function automatic logic [N:0] mul_sat(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] sh;
    logic [N:0]           r;
    ax = PW'($signed(a));
    bx = PW'($signed(b));
    p  = ax * bx;
`ifdef VEC_DOT_ROUND_EN
    p  = p + RND;
`endif
    sh = p >>> Q;
    if ((&sh[PW-1:N-1]) || !(|sh[PW-1:N-1])) begin
      r = {1'b0, sh[N-1:0]};
    end else if (sh[PW-1]) begin
      r = {1'b1, 1'b1, {(N-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(N-1){1'b1}}};
    end
    return r;
  endfunction

  // Select the current group's operands and form the lane products; tail lanes read as zero
  always_comb begin
    int          base;
    logic [N-1:0] a_sel;
    logic [N-1:0] b_sel;
    logic [N:0]   res;
    logic         lane_ok;
    grp_ovf = 1'b0;
    base    = int'(idx_q) * int'(LANES);
    for (int l = 0; l < int'(LANES); l++) begin
      a_sel   = '0;
      b_sel   = '0;
      lane_ok = 1'b0;
      for (int j = 0; j < int'(I); j++) begin
        if (j == base + l) begin
          a_sel   = in_a[j];
          b_sel   = in_b[j];
          lane_ok = 1'b1;
        end
      end
      res         = mul_sat(a_sel, mode_q ? a_sel : b_sel);
      grp_prod[l] = lane_ok ? res[N-1:0] : '0;
      grp_ovf     = grp_ovf | (lane_ok & res[N]);
    end
  end

  // Sum the registered lanes, add to the accumulator and saturate to N bits
  always_comb begin
    logic signed [SW-1:0] lane_sum;
    logic signed [SW-1:0] total;
    lane_sum = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_sum = lane_sum + SW'($signed(prod_q[l]));
    end
    total   = lane_sum + SW'($signed(acc_q));
    acc_ovf = 1'b0;
    if ((&total[SW-1:N-1]) || !(|total[SW-1:N-1])) begin
      acc_sat = total[N-1:0];
    end else begin
      acc_ovf = 1'b1;
      acc_sat = total[SW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == GW'(G - 1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: datapath and status next values
  always_comb begin
    acc_d      = acc_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    prod_d     = prod_q;
    prod_vld_d = prod_vld_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovfl_d     = ovfl_q;

    if (prod_vld_q) begin
      acc_d = acc_sat;
      if (acc_ovf) ovfl_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d      = '0;
          done_d     = 1'b0;
          ovfl_d     = 1'b0;
          idx_d      = '0;
          mode_d     = mode;
          busy_d     = 1'b1;
          prod_vld_d = 1'b0;
        end
      end
      S_RUN: begin
        prod_d     = grp_prod;
        prod_vld_d = 1'b1;
        idx_d      = idx_q + GW'(1);
        if (grp_ovf) ovfl_d = 1'b1;
      end
      S_DRAIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        prod_vld_d = 1'b0;
      end
      default: begin
        busy_d     = 1'b0;
        prod_vld_d = 1'b0;
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      prod_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovfl_q     <= 1'b0;
      for (int l = 0; l < int'(LANES); l++) prod_q[l] <= '0;
    end else begin
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      prod_vld_q <= prod_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovfl_q     <= ovfl_d;
      for (int l = 0; l < int'(LANES); l++) prod_q[l] <= prod_d[l];
    end
  end

  assign out  = acc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovfl = ovfl_q;

endmodule
